// File: rtl/ipsxe_floating_point_segmented_adder_v1_0.sv
// ---------------------------------------------------------------------------
// ipsxe_floating_point_segmented_adder_v1_0
// Pipelined wide two's-complement adder/subtractor. The W = SEG_WIDTH*SEG_NUM
// bit operands are split into SEG_NUM segments, each added in its own stage
// with the inter-segment carry registered, so no carry chain exceeds SEG_WIDTH.
//
// Parameters : SEG_WIDTH (>=2), SEG_NUM (>=1), OUT_REG (0/1)
// Ports      : i_clk, i_rst_n (async, active-low), i_ce (global enable),
//              i_valid, i_sub (0: A+B, 1: A-B), i_a, i_b (W-bit signed)
//              o_valid, o_sum (W), o_cout (MSB carry, 1 = no borrow on sub),
//              o_ovf (signed overflow)
// Latency    : SEG_NUM + OUT_REG enabled cycles.
// Option     : `define IPSXE_FLOATING_POINT_SEGADD_SATURATE_EN to saturate
//              o_sum on signed overflow (default: wrapped result).
// ---------------------------------------------------------------------------
module ipsxe_floating_point_segmented_adder_v1_0 #(
   parameter int unsigned SEG_WIDTH = 24,
   parameter int unsigned SEG_NUM   = 3,
   parameter int unsigned OUT_REG   = 1
) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   input  logic                         i_ce,
   input  logic                         i_valid,
   input  logic                         i_sub,
   input  logic [SEG_WIDTH*SEG_NUM-1:0] i_a,
   input  logic [SEG_WIDTH*SEG_NUM-1:0] i_b,
   output logic                         o_valid,
   output logic [SEG_WIDTH*SEG_NUM-1:0] o_sum,
   output logic                         o_cout,
   output logic                         o_ovf
);

   localparam int unsigned SW = SEG_WIDTH;
   localparam int unsigned W  = SEG_WIDTH * SEG_NUM;

   // Subtract is A + ~B + 1; the +1 enters as the segment-0 carry-in.
   logic [W-1:0]       b_op_c;
   logic [SEG_NUM-1:0] carry_w;
   logic [W-1:0]       sum_w;
   logic               ovf_w;
   logic [SEG_NUM-1:0] valid_q;
`ifdef IPSXE_FLOATING_POINT_SEGADD_SATURATE_EN
   logic               sign_w;
`endif

   assign b_op_c = i_sub ? ~i_b : i_b;

   // Valid shift register, same depth as the segment pipeline.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         valid_q <= '0;
      end else if (i_ce) begin
         valid_q[0] <= i_valid;
         for (int k = 1; k < int'(SEG_NUM); k++) begin
            valid_q[k] <= valid_q[k-1];
         end
      end
   end

   for (genvar j = 0; j < SEG_NUM; j++) begin : g_seg
      localparam int unsigned DSK = SEG_NUM - 1 - j;

      logic [SW-1:0] a_in;
      logic [SW-1:0] b_in;
      logic          cin;
      logic [SW-1:0] lo_c;
      logic [1:0]    hi_c;
      logic [SW-1:0] ps_q;
      logic          c_q;

      // Skew: segment j waits j cycles so it meets the carry of segment j-1.
      if (j == 0) begin : g_head
         assign a_in = i_a[SW-1:0];
         assign b_in = b_op_c[SW-1:0];
         assign cin  = i_sub;
      end else begin : g_skew
         logic [SW-1:0] a_sk_q [j];
         logic [SW-1:0] b_sk_q [j];

         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               for (int k = 0; k < j; k++) begin
                  a_sk_q[k] <= '0;
                  b_sk_q[k] <= '0;
               end
            end else if (i_ce) begin
               a_sk_q[0] <= i_a[j*SW +: SW];
               b_sk_q[0] <= b_op_c[j*SW +: SW];
               for (int k = 1; k < j; k++) begin
                  a_sk_q[k] <= a_sk_q[k-1];
                  b_sk_q[k] <= b_sk_q[k-1];
               end
            end
         end

         assign a_in = a_sk_q[j-1];
         assign b_in = b_sk_q[j-1];
         assign cin  = carry_w[j-1];
      end

      // Split add: lower SW-1 bits first so the carry into the MSB is visible.
      assign lo_c = {1'b0, a_in[SW-2:0]} + {1'b0, b_in[SW-2:0]} + SW'(cin);
      assign hi_c = 2'(a_in[SW-1]) + 2'(b_in[SW-1]) + 2'(lo_c[SW-1]);

      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            ps_q <= '0;
            c_q  <= 1'b0;
         end else if (i_ce) begin
            ps_q <= {hi_c[0], lo_c[SW-2:0]};
            c_q  <= hi_c[1];
         end
      end

      assign carry_w[j] = c_q;

      // Top segment also produces the overflow flag and the A sign.
      if (j == SEG_NUM - 1) begin : g_tail
         logic ovf_q;
`ifdef IPSXE_FLOATING_POINT_SEGADD_SATURATE_EN
         logic sign_q;
`endif
         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               ovf_q  <= 1'b0;
`ifdef IPSXE_FLOATING_POINT_SEGADD_SATURATE_EN
               sign_q <= 1'b0;
`endif
            end else if (i_ce) begin
               ovf_q  <= hi_c[1] ^ lo_c[SW-1];
`ifdef IPSXE_FLOATING_POINT_SEGADD_SATURATE_EN
               sign_q <= a_in[SW-1];
`endif
            end
         end
         assign ovf_w  = ovf_q;
`ifdef IPSXE_FLOATING_POINT_SEGADD_SATURATE_EN
         assign sign_w = sign_q;
`endif
      end

      // Deskew: early segments wait until the top segment of the same
      // transaction has been computed.
      if (DSK == 0) begin : g_nodsk
         assign sum_w[j*SW +: SW] = ps_q;
      end else begin : g_dsk
         logic [SW-1:0] dk_q [DSK];

         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               for (int k = 0; k < int'(DSK); k++) begin
                  dk_q[k] <= '0;
               end
            end else if (i_ce) begin
               dk_q[0] <= ps_q;
               for (int k = 1; k < int'(DSK); k++) begin
                  dk_q[k] <= dk_q[k-1];
               end
            end
         end

         assign sum_w[j*SW +: SW] = dk_q[DSK-1];
      end
   end

   // Result selection (saturation mux only exists when enabled).
   logic [W-1:0] res_sum_c;
`ifdef IPSXE_FLOATING_POINT_SEGADD_SATURATE_EN
   assign res_sum_c = !ovf_w ? sum_w :
                      sign_w ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`else
   assign res_sum_c = sum_w;
`endif

   if (OUT_REG != 0) begin : g_oreg
      logic         valid_o_q;
      logic [W-1:0] sum_o_q;
      logic         cout_o_q;
      logic         ovf_o_q;

      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            valid_o_q <= 1'b0;
            sum_o_q   <= '0;
            cout_o_q  <= 1'b0;
            ovf_o_q   <= 1'b0;
         end else if (i_ce) begin
            valid_o_q <= valid_q[SEG_NUM-1];
            sum_o_q   <= res_sum_c;
            cout_o_q  <= carry_w[SEG_NUM-1];
            ovf_o_q   <= ovf_w;
         end
      end

      assign o_valid = valid_o_q;
      assign o_sum   = sum_o_q;
      assign o_cout  = cout_o_q;
      assign o_ovf   = ovf_o_q;
   end else begin : g_nooreg
      assign o_valid = valid_q[SEG_NUM-1];
      assign o_sum   = res_sum_c;
      assign o_cout  = carry_w[SEG_NUM-1];
      assign o_ovf   = ovf_w;
   end

endmodule

// File: tb/tb_ipsxe_floating_point_segmented_adder_v1_0.sv
// ---------------------------------------------------------------------------
// Self-checking bench for ipsxe_floating_point_segmented_adder_v1_0 with the
// default parameters (W = 72, latency 4). Expected results come from a
// full-width signed/unsigned arithmetic model and an in-order scoreboard.
// ---------------------------------------------------------------------------
module tb_ipsxe_floating_point_segmented_adder_v1_0;

   localparam int unsigned W   = 72;
   localparam int unsigned LAT = 4;

   logic         clk   = 1'b0;
   logic         rst_n = 1'b1;
   logic         ce    = 1'b0;
   logic         valid = 1'b0;
   logic         sub   = 1'b0;
   logic [W-1:0] a     = '0;
   logic [W-1:0] b     = '0;
   logic         o_valid;
   logic [W-1:0] o_sum;
   logic         o_cout;
   logic         o_ovf;

   int unsigned  n_vec  = 0;
   int unsigned  n_err  = 0;
   int unsigned  en_cnt = 0;

   logic [W-1:0] q_sum  [$];
   logic         q_cout [$];
   logic         q_ovf  [$];
   int unsigned  q_t    [$];

   logic         h_valid = 1'b0;
   logic [W-1:0] h_sum   = '0;
   logic         h_cout  = 1'b0;
   logic         h_ovf   = 1'b0;

   ipsxe_floating_point_segmented_adder_v1_0 dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_ce    (ce),
      .i_valid (valid),
      .i_sub   (sub),
      .i_a     (a),
      .i_b     (b),
      .o_valid (o_valid),
      .o_sum   (o_sum),
      .o_cout  (o_cout),
      .o_ovf   (o_ovf)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference: exact signed result in W+2 bits; overflow when it does not
   // fit in W bits; carry-out is the unsigned carry (add) or no-borrow (sub).
   function automatic void ref_model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                                     output logic [W-1:0] r, output logic c, output logic v);
      logic [W+1:0] sx;
      logic [W+1:0] sy;
      logic [W+1:0] ideal;
      logic [W:0]   us;
      sx    = {{2{x[W-1]}}, x};
      sy    = {{2{y[W-1]}}, y};
      ideal = s ? (sx - sy) : (sx + sy);
      v     = (ideal[W+1:W-1] != 3'b000) && (ideal[W+1:W-1] != 3'b111);
      r     = ideal[W-1:0];
      us    = {1'b0, x} + {1'b0, y};
      c     = s ? (x >= y) : us[W];
`ifdef IPSXE_FLOATING_POINT_SEGADD_SATURATE_EN
      if (v) r = x[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
   endfunction

   task automatic observe(input logic c_en);
      logic [W-1:0] es;
      logic         ec;
      logic         eo;
      int unsigned  t0;
      if (!c_en) begin
         check_eq("hold_valid", W'(o_valid), W'(h_valid));
         check_eq("hold_sum", o_sum, h_sum);
         check_eq("hold_cout", W'(o_cout), W'(h_cout));
         check_eq("hold_ovf", W'(o_ovf), W'(h_ovf));
      end else if (o_valid) begin
         if (q_sum.size() == 0) begin
            check_eq("spurious_valid", W'(o_valid), W'(1'b0));
         end else begin
            es = q_sum.pop_front();
            ec = q_cout.pop_front();
            eo = q_ovf.pop_front();
            t0 = q_t.pop_front();
            check_eq("sum", o_sum, es);
            check_eq("cout", W'(o_cout), W'(ec));
            check_eq("ovf", W'(o_ovf), W'(eo));
            check_eq("latency", W'(en_cnt - t0 + 1), W'(LAT));
         end
      end else if (q_t.size() != 0 && (en_cnt - q_t[0] + 1) >= LAT) begin
         check_eq("missing_valid", W'(o_valid), W'(1'b1));
         void'(q_sum.pop_front());
         void'(q_cout.pop_front());
         void'(q_ovf.pop_front());
         void'(q_t.pop_front());
      end
      h_valid = o_valid;
      h_sum   = o_sum;
      h_cout  = o_cout;
      h_ovf   = o_ovf;
   endtask

   task automatic step(input logic c_en, input logic v, input logic s,
                       input logic [W-1:0] x, input logic [W-1:0] y);
      logic [W-1:0] es;
      logic         ec;
      logic         eo;
      @(negedge clk);
      ce    = c_en;
      valid = v;
      sub   = s;
      a     = x;
      b     = y;
      @(posedge clk);
      if (c_en) en_cnt++;
      if (c_en && v) begin
         ref_model(x, y, s, es, ec, eo);
         q_sum.push_back(es);
         q_cout.push_back(ec);
         q_ovf.push_back(eo);
         q_t.push_back(en_cnt);
      end
      #1;
      observe(c_en);
   endtask

   task automatic check_zero_outputs(input string tag);
      check_eq({tag, "_valid"}, W'(o_valid), W'(1'b0));
      check_eq({tag, "_sum"}, o_sum, W'(0));
      check_eq({tag, "_cout"}, W'(o_cout), W'(1'b0));
      check_eq({tag, "_ovf"}, W'(o_ovf), W'(1'b0));
   endtask

   function automatic logic [W-1:0] rnd_op();
      logic [W-1:0] r;
      r = W'({$urandom, $urandom, $urandom});
      case ($urandom_range(0, 7))
         0: r = '0;
         1: r = '1;
         2: r = {1'b1, {(W-1){1'b0}}};
         3: r = {1'b0, {(W-1){1'b1}}};
         4: r = W'(72'h000000_000000_FFFFFF);
         5: r = W'($urandom_range(0, 15));
         default: ;
      endcase
      return r;
   endfunction

   initial begin
      // Power-on reset.
      #1 rst_n = 1'b0;
      #1 check_zero_outputs("rst");
      @(posedge clk);
      @(posedge clk);
      #1 check_zero_outputs("rst_hold");
      @(negedge clk);
      rst_n = 1'b1;

      // Directed cases.
      step(1'b1, 1'b1, 1'b0, 72'h000000_000000_FFFFFF, 72'h1);
      step(1'b1, 1'b1, 1'b0, 72'hFFFFFF_FFFFFF_FFFFFF, 72'h1);
      step(1'b1, 1'b1, 1'b0, 72'h7FFFFF_FFFFFF_FFFFFF, 72'h1);
      step(1'b1, 1'b1, 1'b1, 72'h5, 72'h7);
      step(1'b1, 1'b1, 1'b1, 72'h800000_000000_000000, 72'h1);
      step(1'b1, 1'b1, 1'b1, 72'h0, 72'h0);

      // Streaming with a 2-cycle stall after the 3rd transaction.
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 1'b1, 1'(i % 2), rnd_op(), rnd_op());
         if (i == 2) begin
            step(1'b0, 1'b1, 1'b0, rnd_op(), rnd_op());
            step(1'b0, 1'b1, 1'b1, rnd_op(), rnd_op());
         end
      end
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, '0, '0);

      // Randomized traffic with random enables and valids.
      for (int i = 0; i < 300; i++) begin
         step(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 3) != 0),
              1'($urandom), rnd_op(), rnd_op());
      end
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, '0, '0);
      check_eq("drain_empty", W'(q_sum.size()), W'(0));

      // Reset with three transactions in flight.
      step(1'b1, 1'b1, 1'b0, rnd_op(), rnd_op());
      step(1'b1, 1'b1, 1'b1, rnd_op(), rnd_op());
      step(1'b1, 1'b1, 1'b0, '1, 72'h1);
      #2 rst_n = 1'b0;
      #1 check_zero_outputs("midrst");
      q_sum.delete();
      q_cout.delete();
      q_ovf.delete();
      q_t.delete();
      valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step(1'b1, 1'b0, 1'b0, '0, '0);
         check_eq("post_rst_valid", W'(o_valid), W'(1'b0));
      end

      // Fresh traffic after reset.
      step(1'b1, 1'b1, 1'b0, 72'h123456_789ABC_DEF012, 72'hFEDCBA_987654_321000);
      step(1'b1, 1'b1, 1'b1, 72'h000001_000000_000000, 72'h000000_000000_000001);
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, '0, '0);
      check_eq("final_empty", W'(q_sum.size()), W'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ipsxe_floating_point_segmented_adder_v1_0.md
# ipsxe_floating_point_segmented_adder_v1_0

Pipelined wide two's-complement adder/subtractor for the floating-point datapath (mantissa/partial-product accumulation). The `W = SEG_WIDTH*SEG_NUM` bit operands are split into `SEG_NUM` segments. Each segment is added in its own pipeline stage, and the carry is registered between stages, so no carry chain is longer than `SEG_WIDTH` bits. The block generalises the single-segment `hi + carry` adder: width and segment count are parametrised, it supports add/subtract per transaction, and it adds valid/clock-enable handshaking, overflow detection and optional saturation.

## Interface
- `SEG_WIDTH`, 24: bits per segment; must be ≥ 2.
- `SEG_NUM`, 3: number of segments and of carry pipeline stages; must be ≥ 1.
- `OUT_REG`, 1: 1 adds an output register stage; 0 makes outputs come straight from the last segment stage.
- `i_clk`, input, 1: clock, rising edge.
- `i_rst_n`, input, 1: reset, asynchronous, active-low.
- `i_ce`, input, 1: global clock enable; 0 freezes every pipeline register.
- `i_valid`, input, 1: an operand pair is present this cycle (sampled when `i_ce`=1).
- `i_sub`, input, 1: 0 computes A+B; 1 computes A−B.
- `i_a`, input, W: operand A, signed.
- `i_b`, input, W: operand B, signed.
- `o_valid`, output, 1: result valid.
- `o_sum`, output, W: result, wrapped or saturated (see Configuration).
- `o_cout`, output, 1: unsigned carry-out of the MSB. For subtract, 1 means no borrow.
- `o_ovf`, output, 1: signed overflow flag.

## Operation
- Operand preparation: `B' = i_sub ? ~i_b : i_b`. The segment-0 carry-in is `i_sub`.
- Stage k (k = 1..SEG_NUM):
  - Adds segment k−1 of A and B'.
  - Carry-in is the carry registered by stage k−1; stage 1 uses the `i_sub` carry-in.
  - Registers the `SEG_WIDTH`-bit partial sum and the carry-out.
- Skew registers: segment j of A and B' is delayed j cycles before it enters its stage.
- Deskew registers: the partial sum of segment j is delayed `SEG_NUM−1−j` cycles, so all segments of one transaction align at the output.
- Valid path: `i_valid` travels through a shift register of the same depth. Every stage carries data regardless of valid; only `o_valid` qualifies the output.
- Last stage outputs:
  - `o_cout` = carry out of the MSB.
  - `o_ovf` = carry into the MSB XOR carry out of the MSB.
  - The sign of the skewed A top segment is also tracked for saturation.
- Width rules:
  - Arithmetic is modulo 2^W; there is no widening.
  - For `SEG_NUM`=1 the block is one registered W-bit adder.
- `i_ce`=0: all data, carry and valid registers hold. Outputs stay stable, and no transaction is lost or duplicated.
- Throughput: one transaction per cycle with `i_ce`=1. The block has no backpressure beyond `i_ce`.

## Timing
- Latency from `i_valid` sampled to `o_valid` asserted is `SEG_NUM + OUT_REG` enabled cycles (4 with defaults).
- Reset (`i_rst_n`=0): immediately clears every register, including skew, deskew, carry and valid. While reset is asserted, `o_valid`=0, `o_sum`=0, `o_cout`=0 and `o_ovf`=0.
- Reset mid-operation: all in-flight transactions are discarded. No `o_valid` appears for them after release.
- After reset release, the first sample is taken on the first rising edge with `i_ce`=1.
- A change of `i_sub` between consecutive transactions takes effect per transaction; there is no bubble.
- With `OUT_REG`=0, outputs change on the edge that completes the last segment stage. They remain registered outputs, with no combinational path from the inputs.

## Configuration
- Macro: `IPSXE_FLOATING_POINT_SEGADD_SATURATE_EN`.
- Defined: when `o_ovf`=1, `o_sum` is forced to the saturation limit:
  - If A is negative, the limit is 1 followed by W−1 zeros.
  - Otherwise, it is 0 followed by W−1 ones.
  - `o_ovf` and `o_cout` are still reported.
- Undefined: `o_sum` is the wrapped modulo-2^W result, `o_ovf` is still reported, and the saturation mux is not built.

## Test plan
All cases use the defaults (W=72, latency 4).
- Carry across segments: A=0x000000_000000_FFFFFF, B=1, add → 4 cycles later `o_sum`=0x000000_000001_000000, `o_cout`=0, `o_ovf`=0.
- Full ripple: A=0xFFFFFF_FFFFFF_FFFFFF, B=1, add → `o_sum`=0, `o_cout`=1, `o_ovf`=0.
- Overflow: A=0x7FFFFF_FFFFFF_FFFFFF, B=1 → `o_ovf`=1. With the macro undefined, `o_sum`=0x800000_000000_000000. With the macro defined, `o_sum`=0x7FFFFF_FFFFFF_FFFFFF.
- Subtract: A=5, B=7, `i_sub`=1 → `o_sum`=0xFFFFFF_FFFFFF_FFFFFE, `o_cout`=0, `o_ovf`=0.
- Streaming with stall:
  - Stimulus: 8 back-to-back transactions with alternating `i_sub`; `i_ce`=0 for 2 cycles after the 3rd.
  - Required response: 8 results in order, each matching the reference model; outputs held during the stall; latency = 4 enabled cycles.
- Reset mid-flight: drop `i_rst_n` with 3 transactions in flight → `o_valid`, `o_sum`, `o_cout` and `o_ovf` go to 0 asynchronously, and no `o_valid` appears after release until new input arrives.
